// File: rtl/fdiv_sched_if.sv
// Handshake bundle between the divider issue controller and its requesters, divider and consumer.
// master = requesters/consumer/divider side, slave = fdiv_sched.
interface fdiv_sched_if #(
    parameter int TAG_W = 5
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_x1;
    logic [31:0]      req0_x2;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_x1;
    logic [31:0]      req1_x2;
    logic [TAG_W-1:0] req1_tag;
    logic [31:0]      div_x1;
    logic [31:0]      div_x2;
    logic [31:0]      div_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_y;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_src;
    logic             busy;

    modport master (
        output req0_valid, req0_x1, req0_x2, req0_tag,
        input  req0_ready,
        output req1_valid, req1_x1, req1_x2, req1_tag,
        input  req1_ready,
        input  div_x1, div_x2,
        output div_y,
        input  rsp_valid, rsp_y, rsp_tag, rsp_src, busy,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_x1, req0_x2, req0_tag,
        output req0_ready,
        input  req1_valid, req1_x1, req1_x2, req1_tag,
        output req1_ready,
        output div_x1, div_x2,
        input  div_y,
        output rsp_valid, rsp_y, rsp_tag, rsp_src, busy,
        input  rsp_ready
    );
endinterface

// File: rtl/fdiv_sched.sv
// Issue controller for a non-stallable pipelined divider: round-robin over two requesters, in-flight tracking, result FIFO.
// Latency: result at FIFO head LAT+1 cycles after the issue cycle; one issue per cycle sustained.
// Backpressure: issue is credit-gated so FIFO entries plus in-flight ops never exceed DEPTH.
module fdiv_sched #(
    parameter int LAT   = 5,
    parameter int TAG_W = 5,
    parameter int DEPTH = 8
) (
    input logic         clk,
    input logic         rstn,
    fdiv_sched_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int IW = $clog2(LAT + 1);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
        logic             src;
    } stage_t;

    typedef struct packed {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        logic             src;
    } ent_t;

    stage_t           sr [LAT];
    ent_t             mem [DEPTH];
    ent_t             head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             rr;
    logic [IW-1:0]    inflight;
    logic [SW-1:0]    credit_used;
    logic             can_issue;
    logic             gnt0;
    logic             gnt1;
    logic             issue;
    logic [TAG_W-1:0] iss_tag;
    logic             not_empty;
    logic             push;
    logic             pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + IW'(sr[i].v);
    end

    // Credit uses this cycle's count; a pop only frees a slot from the next cycle.
    assign credit_used = SW'(count) + SW'(inflight);
    assign can_issue   = credit_used < SW'(DEPTH);

    assign gnt0    = rstn & can_issue & bus.req0_valid & (~bus.req1_valid | ~rr);
    assign gnt1    = rstn & can_issue & bus.req1_valid & (~bus.req0_valid |  rr);
    assign issue   = gnt0 | gnt1;
    assign iss_tag = gnt1 ? bus.req1_tag : bus.req0_tag;

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.div_x1     = gnt1 ? bus.req1_x1 : bus.req0_x1;
    assign bus.div_x2     = gnt1 ? bus.req1_x2 : bus.req0_x2;

    assign not_empty = (count != '0);
    assign push      = sr[LAT-1].v;
    assign pop       = not_empty & bus.rsp_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) sr[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr     <= 1'b0;
        end else begin
            sr[0] <= '{v: issue, tag: iss_tag, src: gnt1};
            for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
            if (issue && bus.req0_valid && bus.req1_valid) rr <= ~rr;
        end
    end

    // Last shift stage is time-aligned with the divider output.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{y: bus.div_y, tag: sr[LAT-1].tag, src: sr[LAT-1].src};
    end

    assign head          = mem[rd_ptr];
    assign bus.rsp_valid = not_empty;
    assign bus.rsp_y     = not_empty ? head.y   : '0;
    assign bus.rsp_tag   = not_empty ? head.tag : '0;
    assign bus.rsp_src   = not_empty ? head.src : 1'b0;
    assign bus.busy      = (inflight != '0) | not_empty;
endmodule

// File: tb/tb_fdiv_sched.sv
// Bench for fdiv_sched: behavioural LAT-stage divider, issue-order scoreboard, per-scenario tasks.
module tb_fdiv_sched;
    localparam int LAT   = 5;
    localparam int TAG_W = 5;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        logic             src;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [31:0] dpipe [LAT];
    exp_t        sb [$];
    exp_t        exp_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;

    fdiv_sched_if #(.TAG_W(TAG_W)) b ();

    fdiv_sched #(.LAT(LAT), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Exponent subtraction: exact quotient whenever the divisor is a power of two.
    function automatic logic [31:0] fdiv_model(logic [31:0] a, logic [31:0] d);
        return a - d + 32'h3F800000;
    endfunction

    function automatic logic [31:0] op_x1(int src, int tag);
        return (src != 0 ? 32'h42000000 : 32'h41000000) | (32'(tag) << 12);
    endfunction

    function automatic logic [31:0] op_x2(int tag);
        return 32'h3F800000 + (32'(tag % 4) << 23);
    endfunction

    always @(posedge clk) begin
        dpipe[0] <= fdiv_model(b.div_x1, b.div_x2);
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign b.div_y = dpipe[LAT-1];

    // Scoreboard: pop/compare before pushing so a same-cycle issue cannot mask an empty queue.
    always @(negedge clk) begin
        if (rstn) begin
            if (b.rsp_valid && b.rsp_ready) begin
                n_pops++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: got y=%h tag=%0d src=%0d, expected nothing", b.rsp_y, b.rsp_tag, b.rsp_src);
                end else begin
                    exp_e = sb.pop_front();
                    if ({b.rsp_y, b.rsp_tag, b.rsp_src} !== exp_e) begin
                        n_fail++;
                        $display("FAIL rsp_data: got y=%h tag=%0d src=%0d, expected y=%h tag=%0d src=%0d",
                                 b.rsp_y, b.rsp_tag, b.rsp_src, exp_e.y, exp_e.tag, exp_e.src);
                    end
                end
            end
            if (b.req0_valid && b.req0_ready)
                sb.push_back('{y: fdiv_model(b.req0_x1, b.req0_x2), tag: b.req0_tag, src: 1'b0});
            if (b.req1_valid && b.req1_ready)
                sb.push_back('{y: fdiv_model(b.req1_x1, b.req1_x2), tag: b.req1_tag, src: 1'b1});
            if (dut.push) begin
                n_checks++;
                if (!(dut.count < DEPTH || dut.pop)) begin
                    n_fail++;
                    $display("FAIL fifo_overflow: push with count=%0d and no pop, limit %0d", dut.count, DEPTH);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b.req0_valid = 1'b0; b.req0_x1 = '0; b.req0_x2 = '0; b.req0_tag = '0;
        b.req1_valid = 1'b0; b.req1_x1 = '0; b.req1_x2 = '0; b.req1_tag = '0;
        b.rsp_ready  = 1'b0;
    endtask

    task automatic set_req(int src, bit v, int tag);
        if (src == 0) begin
            b.req0_valid = v; b.req0_x1 = op_x1(0, tag); b.req0_x2 = op_x2(tag); b.req0_tag = TAG_W'(tag);
        end else begin
            b.req1_valid = v; b.req1_x1 = op_x1(1, tag); b.req1_x2 = op_x2(tag); b.req1_tag = TAG_W'(tag);
        end
    endtask

    task automatic reset_dut();
        idle_inputs();
        rstn = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic drain(string name, int max_cycles);
        int c = 0;
        b.rsp_ready = 1'b1;
        while (b.busy && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (b.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: busy=%b after %0d cycles, required 0", name, b.busy, c);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_lost: %0d results never delivered, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        b.req0_valid = 1'b1; b.req1_valid = 1'b1; b.rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({b.rsp_valid, b.busy, b.req0_ready, b.req1_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: rsp_valid/busy/req0_ready/req1_ready=%b, required 0000",
                     {b.rsp_valid, b.busy, b.req0_ready, b.req1_ready});
        end
        n_checks++;
        if ({b.rsp_y, b.rsp_tag, b.rsp_src} !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp: y=%h tag=%0d src=%0d, required all 0", b.rsp_y, b.rsp_tag, b.rsp_src);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        rstn = 1'b1;
    endtask

    task automatic test_single();
        tick();
        b.rsp_ready = 1'b1;
        b.req0_valid = 1'b1; b.req0_x1 = 32'h40C00000; b.req0_x2 = 32'h40000000; b.req0_tag = TAG_W'(3);
        @(negedge clk);
        n_checks++;
        if (b.req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: req0_ready=%b, required 1", b.req0_ready);
        end
        tick();
        b.req0_valid = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (b.rsp_valid !== (k == LAT + 1) || b.busy !== (k <= LAT + 1)) begin
                n_fail++;
                $display("FAIL single_timing: cycle %0d rsp_valid=%b busy=%b, required %b %b",
                         k, b.rsp_valid, b.busy, (k == LAT + 1), (k <= LAT + 1));
            end
            if (k == LAT + 1) begin
                n_checks++;
                if (b.rsp_y !== 32'h40400000 || b.rsp_tag !== TAG_W'(3) || b.rsp_src !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_result: y=%h tag=%0d src=%0d, required 40400000 3 0",
                             b.rsp_y, b.rsp_tag, b.rsp_src);
                end
            end
        end
    endtask

    task automatic test_contention();
        int  t0 = 0;
        int  t1 = 16;
        bit  g0;
        reset_dut();
        tick();
        b.rsp_ready = 1'b1;
        set_req(0, 1'b1, t0);
        set_req(1, 1'b1, t1);
        for (int i = 0; i < 8; i++) begin
            g0 = (i % 2 == 0);
            @(negedge clk);
            n_checks++;
            if ({b.req0_ready, b.req1_ready} !== {g0, ~g0}) begin
                n_fail++;
                $display("FAIL contention_grant: cycle %0d ready0/1=%b, required %b",
                         i, {b.req0_ready, b.req1_ready}, {g0, ~g0});
            end
            tick();
            if (g0) begin t0++; set_req(0, 1'b1, t0); end
            else    begin t1++; set_req(1, 1'b1, t1); end
        end
        b.req0_valid = 1'b0;
        b.req1_valid = 1'b0;
        drain("contention", 4 * LAT + 16);
    endtask

    task automatic test_credit();
        int acc = 0;
        int tg  = 0;
        int p0;
        bit took;
        reset_dut();
        p0 = n_pops;
        tick();
        set_req(0, 1'b1, tg);
        for (int c = 0; c < DEPTH + LAT + 6; c++) begin
            @(negedge clk);
            took = b.req0_ready;
            if (took) acc++;
            tick();
            if (took) begin tg++; set_req(0, 1'b1, tg); end
        end
        n_checks++;
        if (acc != DEPTH) begin
            n_fail++;
            $display("FAIL credit_accepts: accepted %0d with rsp_ready low, required %0d", acc, DEPTH);
        end
        b.rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (b.req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_same_cycle: req0_ready=%b during pop cycle, required 0", b.req0_ready);
        end
        tick();
        b.rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b.req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_return: req0_ready=%b after pop, required 1", b.req0_ready);
        end
        tick();
        b.req0_valid = 1'b0;
        drain("credit", 4 * DEPTH + 4 * LAT);
        n_checks++;
        if (n_pops - p0 != DEPTH + 1) begin
            n_fail++;
            $display("FAIL credit_count: delivered %0d results, required %0d", n_pops - p0, DEPTH + 1);
        end
    endtask

    task automatic test_back_to_back();
        int  p0;
        bit  want_v;
        reset_dut();
        p0 = n_pops;
        tick();
        b.rsp_ready = 1'b1;
        for (int c = 0; c <= LAT + 22; c++) begin
            if (c < 20) set_req(0, 1'b1, c);
            else        b.req0_valid = 1'b0;
            @(negedge clk);
            if (c < 20) begin
                n_checks++;
                if (b.req0_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready: cycle %0d req0_ready=%b, required 1", c, b.req0_ready);
                end
            end
            want_v = (c >= LAT + 1) && (c <= LAT + 20);
            n_checks++;
            if (b.rsp_valid !== want_v) begin
                n_fail++;
                $display("FAIL b2b_rsp_valid: cycle %0d rsp_valid=%b, required %b", c, b.rsp_valid, want_v);
            end
            tick();
        end
        drain("b2b", 2 * LAT + 8);
        n_checks++;
        if (n_pops - p0 != 20) begin
            n_fail++;
            $display("FAIL b2b_count: delivered %0d results, required 20", n_pops - p0);
        end
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        int c = 0;
        reset_dut();
        tick();
        b.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, i + 4);
            tick();
        end
        b.req0_valid = 1'b0;
        tick();
        tick();
        rstn = 1'b0;
        sb.delete();
        #1;
        n_checks++;
        if (b.rsp_valid !== 1'b0 || b.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: rsp_valid=%b busy=%b, required 0 0", b.rsp_valid, b.busy);
        end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            if (b.rsp_valid !== 1'b0) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL midreset_stale: rsp_valid seen in %0d cycles after release, required 0", stale);
        end
        tick();
        b.req1_valid = 1'b1; b.req1_x1 = 32'h41400000; b.req1_x2 = 32'h40800000; b.req1_tag = TAG_W'(9);
        tick();
        b.req1_valid = 1'b0;
        while (!b.rsp_valid && c < 3 * LAT) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (b.rsp_valid !== 1'b1 || b.rsp_y !== 32'h40400000 || b.rsp_tag !== TAG_W'(9) || b.rsp_src !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_new_op: valid=%b y=%h tag=%0d src=%0d, required 1 40400000 9 1",
                     b.rsp_valid, b.rsp_y, b.rsp_tag, b.rsp_src);
        end
        drain("midreset", 2 * LAT + 4);
    endtask

    task automatic test_push_pop();
        logic [31:0] ya;
        logic [31:0] yb;
        ya = fdiv_model(op_x1(0, 20), op_x2(20));
        yb = fdiv_model(op_x1(0, 21), op_x2(21));
        reset_dut();
        tick();
        set_req(0, 1'b1, 20);
        tick();
        set_req(0, 1'b1, 21);
        tick();
        b.req0_valid = 1'b0;
        for (int c = 2; c <= LAT; c++) tick();
        b.rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dut.count !== 4'd1 || b.rsp_y !== ya) begin
            n_fail++;
            $display("FAIL pushpop_before: count=%0d y=%h, required 1 %h", dut.count, b.rsp_y, ya);
        end
        tick();
        b.rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut.count !== 4'd1 || b.rsp_y !== yb || b.rsp_tag !== TAG_W'(21)) begin
            n_fail++;
            $display("FAIL pushpop_after: count=%0d y=%h tag=%0d, required 1 %h 21", dut.count, b.rsp_y, b.rsp_tag, yb);
        end
        drain("pushpop", 2 * LAT + 4);
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_credit();
        test_back_to_back();
        test_reset_midflight();
        test_push_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
